// File: rtl/alu_control_mc.sv
// ALU control decoder with a multicycle multiply/divide sequencer (IDLE -> BUSY -> DONE).
// Define MDU_DIV_EN to treat DIV/DIVU as sequencer ops; otherwise they decode as unknown.
module alu_control_mc #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [2:0] ALUOp,
    input  logic [5:0] ALUFunction,
    output logic [3:0] ALUOperation,
    output logic       jr,
    output logic       stall,
    output logic       busy,
    output logic       mdu_start,
    output logic [1:0] mdu_op,
    output logic       hilo_we,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES - 1);
    localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       is_r;
    logic       is_mdu;
    logic       is_mf;
    logic       is_jr;
    logic       accept;
    logic [3:0] dec_code;

    function automatic logic [3:0] decode(input logic [2:0] op, input logic [5:0] fn);
        logic [3:0] code;
        code = 4'b1001;
        if (op == 3'b111) begin
            case (fn)
                6'b100100: code = 4'b0000;
                6'b100101: code = 4'b0001;
                6'b100111: code = 4'b0010;
                6'b100000: code = 4'b0011;
                6'b100010: code = 4'b0100;
                6'b000010: code = 4'b0101;
                6'b000000: code = 4'b0110;
                6'b101010: code = 4'b0111;
                default:   code = 4'b1001;
            endcase
        end else begin
            case (op)
                3'b100:  code = 4'b0011;
                3'b101:  code = 4'b0001;
                3'b011:  code = 4'b0000;
                3'b010:  code = 4'b0011;
                3'b110:  code = 4'b0011;
                default: code = 4'b1001;
            endcase
        end
        return code;
    endfunction

    assign is_r = (ALUOp == 3'b111);
`ifdef MDU_DIV_EN
    assign is_mdu = is_r && (ALUFunction[5:2] == 4'b0110);
`else
    assign is_mdu = is_r && (ALUFunction[5:1] == 5'b01100);
`endif
    assign is_mf    = is_r && ((ALUFunction == 6'b010000) || (ALUFunction == 6'b010010));
    assign is_jr    = is_r && (ALUFunction == 6'b001000);
    assign dec_code = decode(ALUOp, ALUFunction);

    // Handshake: valid offers an instruction; it is taken on a rising edge when valid && !stall.
    // stall only blocks ops that need the sequencer or its HI/LO result while it is busy.
    assign busy      = (state != IDLE);
    assign stall     = valid && busy && (is_mdu || is_mf);
    assign accept    = valid && !stall;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ALUOperation <= 4'b1001;
            jr           <= 1'b0;
            state        <= IDLE;
            cnt          <= 8'd0;
            mdu_start    <= 1'b0;
            mdu_op       <= 2'b00;
            hilo_we      <= 1'b0;
        end else begin
            ALUOperation <= accept ? dec_code : 4'b1001;
            jr           <= accept && is_jr;
            mdu_start    <= 1'b0;
            hilo_we      <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && is_mdu) begin
                        state     <= BUSY;
                        cnt       <= ALUFunction[1] ? DIV_LOAD : MULT_LOAD;
                        mdu_start <= 1'b1;
                        mdu_op    <= ALUFunction[1:0];
                    end
                end
                BUSY: begin
                    // hilo_we is registered, so raise it on the edge entering DONE.
                    if (cnt == 8'd0) begin
                        state   <= DONE;
                        hilo_we <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_control_mc.md
ALU_CONTROL_MC -- requirements
Module: alu_control_mc

Interface
REQ-001 Parameter MULT_CYCLES, default 4: number of BUSY cycles for MULT/MULTU (legal range 1..255).
REQ-002 Parameter DIV_CYCLES, default 32: number of BUSY cycles for DIV/DIVU (legal range 1..255).
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port valid, input, 1: an instruction is presented on ALUOp/ALUFunction this cycle.
REQ-006 Port ALUOp, input, 3: main-decoder operation class.
REQ-007 Port ALUFunction, input, 6: R-type funct field.
REQ-008 Port ALUOperation, output, 4: registered ALU operation code.
REQ-009 Port jr, output, 1: registered jump-register flag.
REQ-010 Port stall, output, 1: combinational; the presented instruction is not accepted this cycle.
REQ-011 Port busy, output, 1: the multiply/divide sequencer is not in IDLE.
REQ-012 Port mdu_start, output, 1: registered one-cycle start pulse to the multiply/divide datapath.
REQ-013 Port mdu_op, output, 2: registered MDU opcode: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-014 Port hilo_we, output, 1: registered one-cycle HI/LO write-enable.

Function
REQ-015 Decode table (ALUOp_funct -> code): 111_100100 AND 0000; 111_100101 OR 0001; 111_100111 NOR 0010; 111_100000 ADD 0011; 111_100010 SUB 0100; 111_000010 SRL 0101; 111_000000 SLL 0110; 111_101010 SLT 0111.
REQ-016 I-type decode ignores funct: 100 ADDI 0011; 101 ORI 0001; 011 ANDI 0000; 010 LW 0011; 110 SW 0011.
REQ-017 All other encodings, including MDU ops and JR, SHALL decode to 1001.
REQ-018 jr SHALL be 1 only for 111_001000.
REQ-019 Acceptance = valid && !stall; on an accepted cycle ALUOperation and jr take the decoded values at the next edge, giving 1-cycle latency.
REQ-020 When no instruction is accepted, ALUOperation SHALL load 1001 and jr SHALL load 0 at the next edge.
REQ-021 MDU ops are 111_011000 MULT, 111_011001 MULTU, 111_011010 DIV and 111_011011 DIVU.
REQ-022 The sequencer SHALL have three states: IDLE, BUSY and DONE.
REQ-023 IDLE with an accepted MDU op -> BUSY; at the same edge load cnt with the op's CYCLES-1, set mdu_start=1 and load mdu_op.
REQ-024 mdu_start SHALL be high for exactly the first BUSY cycle.
REQ-025 In BUSY, cnt decrements each cycle; BUSY with cnt==0 -> DONE, so BUSY lasts exactly CYCLES cycles.
REQ-026 DONE lasts one cycle with hilo_we=1, then -> IDLE; hilo_we is 0 in every other state.
REQ-027 busy=1 in BUSY and DONE.
REQ-028 stall = valid && busy && (funct is an MDU op, MFHI 010000 or MFLO 010010, with ALUOp 111).
REQ-029 Non-MDU instructions are accepted during BUSY and DONE without stall.
REQ-030 An MDU op stalled in DONE is accepted in the following IDLE cycle, giving a back-to-back restart.
REQ-031 mdu_op SHALL hold its value until the next accepted MDU op.

Reset
REQ-032 Asserting reset at any time, including mid-BUSY, SHALL immediately set the following: ALUOperation=1001, jr=0, state=IDLE, cnt=0, mdu_start=0, mdu_op=00, hilo_we=0.
REQ-033 An operation aborted by reset SHALL NOT produce hilo_we.
REQ-034 First acceptance is possible on the first rising edge after reset deasserts.

Configuration
REQ-035 Macro MDU_DIV_EN defined: DIV/DIVU SHALL behave as MDU ops using DIV_CYCLES.
REQ-036 Macro MDU_DIV_EN undefined: DIV/DIVU SHALL decode to 1001, SHALL NOT start the sequencer and SHALL NOT stall; DIV_CYCLES is unused.

Verification
REQ-037 Reset, then valid ADD (111_100000) -> ALUOperation=0011 one cycle later, jr=0; then JR (111_001000) -> jr=1, ALUOperation=1001.
REQ-038 With MULT_CYCLES=4, valid MULT -> mdu_start=1 in cycle 1, busy=1 for cycles 1-5, hilo_we=1 in cycle 5 only, busy=0 in cycle 6.
REQ-039 With MULT in BUSY, present MFLO then ORI (101) -> stall=1 for MFLO until DONE ends; the ORI is accepted with stall=0 and ALUOperation=0001.
REQ-040 MULT followed immediately by DIVU (MDU_DIV_EN defined, DIV_CYCLES=32) -> DIVU is stalled, accepted the cycle after DONE, and mdu_op=11 with BUSY lasting 32 cycles.
REQ-041 Assert reset in the third BUSY cycle of a DIV -> all outputs take their reset values immediately, and hilo_we stays 0.
REQ-042 With MDU_DIV_EN undefined, valid DIV -> busy stays 0, stall=0, ALUOperation=1001.
